led_sdi_decoder: RTL and testbench

- Receive-side counterpart of the LED string driver. Samples one single-wire NRZ LED data line (WS2812-style, pulse-width encoded) and decodes it into DATA_WIDTH-bit pixel words, MSB first.
- Detects the latch/reset gap, reports per-frame pixel counts and flags protocol errors.
- Used for loopback checking of string outputs and as an input port for daisy-chained LED data.

---
 rtl/led_proto_pkg.sv | 22 ++
 rtl/led_sdi_decoder_sync.sv | 32 +++
 rtl/led_sdi_decoder.sv | 173 +++++++++++++++++
 tb/tb_led_sdi_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_proto_pkg.sv
// Shared LED single-wire protocol definitions: decoder states, nanosecond
// timing defaults common with the string driver, and ns-to-cycle conversion.
package led_proto_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam int unsigned LED_T0H_NS    = 400;
    localparam int unsigned LED_T1H_NS    = 800;
    localparam int unsigned LED_T_BIT_NS  = 1250;
    localparam int unsigned LED_T_RESET_NS = 50000;

    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input int unsigned period_ns);
        return (ns + period_ns - 1) / period_ns;
    endfunction

endpackage

// File: rtl/led_sdi_decoder_sync.sv
// Two-flop synchronizer for the LED data line plus one edge-detect register;
// provides the synchronized level and single-cycle rise/fall strobes.
module sdi_sync (
    input  logic clk,
    input  logic reset,
    input  logic sdi_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= sdi_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/led_sdi_decoder.sv
// Pulse-width decoder for a WS2812-style single-wire LED line.
// Optional saturating error counter enabled by defining LED_DECODER_ERR_CNT_EN.
module led_sdi_decoder
    import led_proto_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS   = 50,
    parameter int unsigned DATA_WIDTH      = 24,
    parameter int unsigned T_BIT_THRESH_NS = (LED_T0H_NS + LED_T1H_NS) / 2,
    parameter int unsigned T_MIN_HIGH_NS   = 150,
    parameter int unsigned T_MAX_HIGH_NS   = 2000,
    parameter int unsigned T_RESET_NS      = LED_T_RESET_NS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sdi_in,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_valid,
    output logic                  frame_end,
    output logic [15:0]           frame_pixels,
    output logic                  decode_error,
    output logic [15:0]           err_count,
    output logic                  line_idle
);

    localparam int unsigned BIT_CYC = ns_to_cycles(T_BIT_THRESH_NS, CLK_PERIOD_NS);
    localparam int unsigned MIN_CYC = ns_to_cycles(T_MIN_HIGH_NS, CLK_PERIOD_NS);
    localparam int unsigned MAX_CYC = ns_to_cycles(T_MAX_HIGH_NS, CLK_PERIOD_NS);
    localparam int unsigned RST_CYC = ns_to_cycles(T_RESET_NS, CLK_PERIOD_NS);
    localparam int unsigned CW      = $clog2(RST_CYC) + 1;
    localparam int unsigned BW      = $clog2(DATA_WIDTH) + 1;

    logic level;
    logic rise;
    logic fall;

    sdi_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .sdi_in (sdi_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [15:0]           pix_cnt, pix_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  fend_n;
    logic [15:0]           fpix_n;
    logic                  err_n;
    logic                  bit_val;

    assign bit_val = (cnt >= CW'(BIT_CYC));

    always_comb begin
        state_n = state;
        cnt_n   = (rise || fall) ? CW'(1) : ((&cnt) ? cnt : cnt + CW'(1));
        bit_n   = bit_cnt;
        pix_n   = pix_cnt;
        shift_n = shift;
        data_n  = pixel_data;
        valid_n = 1'b0;
        fend_n  = 1'b0;
        fpix_n  = frame_pixels;
        err_n   = 1'b0;

        case (state)
            SYNC: begin
                // A rise that lands exactly on a completed gap starts a frame directly
                if (cnt >= CW'(RST_CYC) && !level) begin
                    state_n = IDLE;
                end else if (cnt >= CW'(RST_CYC) && rise) begin
                    state_n = HIGH;
                    bit_n   = '0;
                    pix_n   = '0;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    bit_n   = '0;
                    pix_n   = '0;
                end
            end
            HIGH: begin
                if (cnt > CW'(MAX_CYC)) begin
                    err_n   = 1'b1;
                    state_n = SYNC;
                end else if (fall) begin
                    if (cnt < CW'(MIN_CYC)) begin
                        err_n   = 1'b1;
                        state_n = SYNC;
                    end else begin
                        shift_n = {shift[DATA_WIDTH-2:0], bit_val};
                        state_n = LOW;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            valid_n = 1'b1;
                            data_n  = shift_n;
                            bit_n   = '0;
                            if (pix_cnt != 16'hFFFF) begin
                                pix_n = pix_cnt + 16'd1;
                            end
                        end else begin
                            bit_n = bit_cnt + BW'(1);
                        end
                    end
                end
            end
            LOW: begin
                // Latch is resolved before a coincident rise opens the next frame
                if (cnt >= CW'(RST_CYC)) begin
                    fend_n  = 1'b1;
                    fpix_n  = pix_cnt;
                    err_n   = (bit_cnt != '0);
                    state_n = IDLE;
                    if (rise) begin
                        state_n = HIGH;
                        bit_n   = '0;
                        pix_n   = '0;
                    end
                end else if (rise) begin
                    state_n = HIGH;
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SYNC;
            cnt          <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shift        <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            frame_end    <= 1'b0;
            frame_pixels <= '0;
            decode_error <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_cnt      <= bit_n;
            pix_cnt      <= pix_n;
            shift        <= shift_n;
            pixel_data   <= data_n;
            pixel_valid  <= valid_n;
            frame_end    <= fend_n;
            frame_pixels <= fpix_n;
            decode_error <= err_n;
        end
    end

    assign line_idle = (state == SYNC) || (state == IDLE);

`ifdef LED_DECODER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (decode_error && !(&err_count)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_led_sdi_decoder.sv
// Randomized bench for led_sdi_decoder: the line is driven as a list of
// level/width segments and a segment-level protocol model predicts the events.
module tb_led_sdi_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdi;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_end;
    logic [15:0] frame_pixels;
    logic        decode_error;
    logic [15:0] err_count;
    logic        line_idle;

    always #25 clk = ~clk;

    led_sdi_decoder #(
        .CLK_PERIOD_NS   (50),
        .DATA_WIDTH      (24),
        .T_BIT_THRESH_NS (600),
        .T_MIN_HIGH_NS   (150),
        .T_MAX_HIGH_NS   (2000),
        .T_RESET_NS      (50000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sdi_in       (sdi),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_end    (frame_end),
        .frame_pixels (frame_pixels),
        .decode_error (decode_error),
        .err_count    (err_count),
        .line_idle    (line_idle)
    );

    typedef struct {
        bit          lvl;
        int unsigned len;
    } seg_t;

    seg_t        segs[$];
    logic [23:0] exp_pix[$];
    int unsigned exp_frames[$];
    int unsigned exp_err;

    logic [23:0] got_pix[$];
    int unsigned got_frames[$];
    int unsigned got_err;
    int unsigned got_fe_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always @(negedge clk) begin
        if (pixel_valid === 1'b1) got_pix.push_back(pixel_data);
        if (frame_end === 1'b1) begin
            got_frames.push_back(frame_pixels);
            if (decode_error === 1'b1) got_fe_err++;
        end
        if (decode_error === 1'b1) got_err++;
    end

    // Protocol rules applied to whole pulse widths: highs of 3..40 cycles are
    // bits (>=12 is a one), a low of 1000+ cycles latches or re-synchronizes.
    task automatic model_run();
        bit          synced   = 1'b0;
        bit          in_frame = 1'b0;
        logic [23:0] acc      = '0;
        int unsigned nb       = 0;
        int unsigned np       = 0;
        exp_pix.delete();
        exp_frames.delete();
        exp_err = 0;
        foreach (segs[i]) begin
            if (segs[i].lvl) begin
                if (synced) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        nb = 0;
                        np = 0;
                    end
                    if (segs[i].len > 40 || segs[i].len < 3) begin
                        exp_err++;
                        synced   = 1'b0;
                        in_frame = 1'b0;
                    end else begin
                        acc = {acc[22:0], segs[i].len >= 12};
                        nb++;
                        if (nb == 24) begin
                            exp_pix.push_back(acc);
                            nb = 0;
                            if (np < 65535) np++;
                        end
                    end
                end
            end else if (!synced) begin
                if (segs[i].len >= 1000) synced = 1'b1;
            end else if (in_frame && segs[i].len >= 1000) begin
                exp_frames.push_back(np);
                if (nb != 0) exp_err++;
                in_frame = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] exp_ec(input int unsigned n);
`ifdef LED_DECODER_ERR_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n == 0) ? 16'h0 : 16'h0;
`endif
    endfunction

    task automatic drive(input bit lvl, input int unsigned len);
        segs.push_back('{lvl: lvl, len: len});
        sdi = lvl;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        drive(1'b1, b ? $urandom_range(12, 14) : $urandom_range(3, 5));
        drive(1'b0, $urandom_range(1, 3));
    endtask

    task automatic send_pixel(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sdi   = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        segs.delete();
        got_pix.delete();
        got_frames.delete();
        got_err    = 0;
        got_fe_err = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        sdi   = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pixel_data !== 24'h0) begin bad++; $display("FAIL reset pixel_data got=%h exp=0", pixel_data); end
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset pixel_valid got=%b exp=0", pixel_valid); end
        total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset frame_end got=%b exp=0", frame_end); end
        total++; if (frame_pixels !== 16'h0) begin bad++; $display("FAIL reset frame_pixels got=%0d exp=0", frame_pixels); end
        total++; if (decode_error !== 1'b0) begin bad++; $display("FAIL reset decode_error got=%b exp=0", decode_error); end
        total++; if (err_count !== 16'h0) begin bad++; $display("FAIL reset err_count got=%0d exp=0", err_count); end
        total++; if (line_idle !== 1'b1) begin bad++; $display("FAIL reset line_idle got=%b exp=1", line_idle); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [23:0] v = 24'hA5C33C;
        do_reset();
        drive(1'b0, 1100);
        for (int i = 23; i >= 0; i--) begin
            drive(1'b1, v[i] ? 16 : 8);
            drive(1'b0, v[i] ? 9 : 17);
        end
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != 1) begin bad++; $display("FAIL single n_pixels got=%0d exp=1", got_pix.size()); end
        if (got_pix.size() >= 1) begin
            total++; if (got_pix[0] !== 24'hA5C33C) begin bad++; $display("FAIL single pixel got=%h exp=a5c33c", got_pix[0]); end
        end
        total++; if (got_frames.size() != exp_frames.size()) begin bad++; $display("FAIL single n_frames got=%0d exp=%0d", got_frames.size(), exp_frames.size()); end
        total++; if (frame_pixels !== 16'd1) begin bad++; $display("FAIL single frame_pixels got=%0d exp=1", frame_pixels); end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL single errors got=%0d exp=%0d", got_err, exp_err); end
        total++; if (line_idle !== 1'b1) begin bad++; $display("FAIL single line_idle got=%b exp=1", line_idle); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] base = 24'($urandom);
        do_reset();
        drive(1'b0, 1100);
        for (int p = 0; p < 150; p++) send_pixel(base + 24'(p));
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != exp_pix.size()) begin bad++; $display("FAIL b2b n_pixels got=%0d exp=%0d", got_pix.size(), exp_pix.size()); end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            total++; if (got_pix[i] !== exp_pix[i]) begin bad++; $display("FAIL b2b pixel[%0d] got=%h exp=%h", i, got_pix[i], exp_pix[i]); end
        end
        total++; if (got_frames.size() != 1) begin bad++; $display("FAIL b2b n_frames got=%0d exp=1", got_frames.size()); end
        if (got_frames.size() >= 1) begin
            total++; if (got_frames[0] != 150) begin bad++; $display("FAIL b2b frame_pixels got=%0d exp=150", got_frames[0]); end
        end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL b2b errors got=%0d exp=%0d", got_err, exp_err); end
    endtask

    task automatic test_glitch();
        do_reset();
        drive(1'b0, 1100);
        send_pixel(24'($urandom));
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        drive(1'b1, 2);
        drive(1'b0, 1100);
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != exp_pix.size()) begin bad++; $display("FAIL glitch n_pixels got=%0d exp=%0d", got_pix.size(), exp_pix.size()); end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            total++; if (got_pix[i] !== exp_pix[i]) begin bad++; $display("FAIL glitch pixel[%0d] got=%h exp=%h", i, got_pix[i], exp_pix[i]); end
        end
        total++; if (got_frames.size() != exp_frames.size()) begin bad++; $display("FAIL glitch n_frames got=%0d exp=%0d", got_frames.size(), exp_frames.size()); end
        foreach (exp_frames[i]) if (i < got_frames.size()) begin
            total++; if (got_frames[i] != exp_frames[i]) begin bad++; $display("FAIL glitch frame[%0d] got=%0d exp=%0d", i, got_frames[i], exp_frames[i]); end
        end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL glitch errors got=%0d exp=%0d", got_err, exp_err); end
        total++; if (err_count !== exp_ec(exp_err)) begin bad++; $display("FAIL glitch err_count got=%0d exp=%0d", err_count, exp_ec(exp_err)); end
    endtask

    task automatic test_stuck_high();
        do_reset();
        drive(1'b0, 1100);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        drive(1'b1, 40);
        drive(1'b0, 5);
        total++; if (line_idle !== 1'b0) begin bad++; $display("FAIL stuck mid_frame line_idle got=%b exp=0", line_idle); end
        drive(1'b1, 41);
        drive(1'b0, 6);
        total++; if (line_idle !== 1'b1) begin bad++; $display("FAIL stuck after_error line_idle got=%b exp=1", line_idle); end
        total++; if (got_err != 1) begin bad++; $display("FAIL stuck error_strobes got=%0d exp=1", got_err); end
        drive(1'b0, 1100);
        send_pixel(24'($urandom));
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != exp_pix.size()) begin bad++; $display("FAIL stuck n_pixels got=%0d exp=%0d", got_pix.size(), exp_pix.size()); end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            total++; if (got_pix[i] !== exp_pix[i]) begin bad++; $display("FAIL stuck pixel[%0d] got=%h exp=%h", i, got_pix[i], exp_pix[i]); end
        end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL stuck errors got=%0d exp=%0d", got_err, exp_err); end
        total++; if (err_count !== exp_ec(exp_err)) begin bad++; $display("FAIL stuck err_count got=%0d exp=%0d", err_count, exp_ec(exp_err)); end
    endtask

    task automatic test_partial();
        do_reset();
        drive(1'b0, 1100);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        drive(1'b0, 1100);
        model_run();
        total++; if (got_frames.size() != exp_frames.size()) begin bad++; $display("FAIL partial n_frames got=%0d exp=%0d", got_frames.size(), exp_frames.size()); end
        foreach (exp_frames[i]) if (i < got_frames.size()) begin
            total++; if (got_frames[i] != exp_frames[i]) begin bad++; $display("FAIL partial frame[%0d] got=%0d exp=%0d", i, got_frames[i], exp_frames[i]); end
        end
        total++; if (got_fe_err != 1) begin bad++; $display("FAIL partial end_with_error got=%0d exp=1", got_fe_err); end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL partial errors got=%0d exp=%0d", got_err, exp_err); end
        total++; if (got_pix.size() != 0) begin bad++; $display("FAIL partial n_pixels got=%0d exp=0", got_pix.size()); end
    endtask

    task automatic test_boundaries();
        logic [23:0] v;
        int unsigned lows[3] = '{1, 2, 999};
        do_reset();
        drive(1'b0, 1100);
        for (int p = 0; p < 3; p++) begin
            v = 24'($urandom);
            for (int i = 23; i >= 0; i--) begin
                drive(1'b1, v[i] ? (($urandom % 2) ? 12 : 40) : (($urandom % 2) ? 3 : 11));
                drive(1'b0, (p == 1 && i == 0) ? 1000 : lows[$urandom_range(0, 2)]);
            end
        end
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != exp_pix.size()) begin bad++; $display("FAIL bound n_pixels got=%0d exp=%0d", got_pix.size(), exp_pix.size()); end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            total++; if (got_pix[i] !== exp_pix[i]) begin bad++; $display("FAIL bound pixel[%0d] got=%h exp=%h", i, got_pix[i], exp_pix[i]); end
        end
        total++; if (got_frames.size() != exp_frames.size()) begin bad++; $display("FAIL bound n_frames got=%0d exp=%0d", got_frames.size(), exp_frames.size()); end
        foreach (exp_frames[i]) if (i < got_frames.size()) begin
            total++; if (got_frames[i] != exp_frames[i]) begin bad++; $display("FAIL bound frame[%0d] got=%0d exp=%0d", i, got_frames[i], exp_frames[i]); end
        end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL bound errors got=%0d exp=%0d", got_err, exp_err); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] v = 24'($urandom);
        do_reset();
        drive(1'b0, 1100);
        send_pixel(v);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom));
        total++; if (got_pix.size() != 1) begin bad++; $display("FAIL midreset first_pixels got=%0d exp=1", got_pix.size()); end
        if (got_pix.size() >= 1) begin
            total++; if (got_pix[0] !== v) begin bad++; $display("FAIL midreset first_pixel got=%h exp=%h", got_pix[0], v); end
        end
        total++; if (line_idle !== 1'b0) begin bad++; $display("FAIL midreset busy line_idle got=%b exp=0", line_idle); end
        got_pix.delete();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pixel_data !== 24'h0) begin bad++; $display("FAIL midreset pixel_data got=%h exp=0", pixel_data); end
        total++; if (line_idle !== 1'b1) begin bad++; $display("FAIL midreset line_idle got=%b exp=1", line_idle); end
        total++; if (frame_pixels !== 16'h0) begin bad++; $display("FAIL midreset frame_pixels got=%0d exp=0", frame_pixels); end
        reset = 1'b0;
        segs.delete();
        drive(1'b0, 20);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom));
        drive(1'b0, 1100);
        send_pixel(24'($urandom));
        drive(1'b0, 1100);
        model_run();
        total++; if (got_pix.size() != exp_pix.size()) begin bad++; $display("FAIL midreset n_pixels got=%0d exp=%0d", got_pix.size(), exp_pix.size()); end
        foreach (exp_pix[i]) if (i < got_pix.size()) begin
            total++; if (got_pix[i] !== exp_pix[i]) begin bad++; $display("FAIL midreset pixel[%0d] got=%h exp=%h", i, got_pix[i], exp_pix[i]); end
        end
        total++; if (got_frames.size() != exp_frames.size()) begin bad++; $display("FAIL midreset n_frames got=%0d exp=%0d", got_frames.size(), exp_frames.size()); end
        total++; if (got_err != exp_err) begin bad++; $display("FAIL midreset errors got=%0d exp=%0d", got_err, exp_err); end
    endtask

    initial begin
        reset = 1'b1;
        sdi   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_stuck_high();
        test_partial();
        test_boundaries();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
